// File: rtl/fp_issue_seq.sv
// Single-outstanding FPU issue sequencer: holds control fields for each op's
// fixed latency, buffers one follow-on op, and pulses the write-back strobe.
module fp_issue_seq #(
    parameter int LAT_ADD  = 1,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 12,
    parameter int LAT_CVT  = 2,
    parameter int CNT_W    = 4
) (
    input  logic        cpu_clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [2:0]  op,
    input  logic        use_imm,
    input  logic        dst_rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic        abort,
    output logic [2:0]  fp_alu_ctrl,
    output logic        fp_alu_src,
    output logic        fp_reg_dst,
    output logic [4:0]  fp_rs,
    output logic [4:0]  fp_rt,
    output logic [4:0]  fp_rd,
    output logic [15:0] fp_imm,
    output logic        reg_write,
    output logic        done,
    output logic        illegal_op,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  op;
        logic        use_imm;
        logic        dst_rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } fop_t;

    localparam logic [2:0] OP_ILL = 3'b111;

    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] code);
        case (code)
            3'b000, 3'b001: lat_of = CNT_W'(LAT_ADD);
            3'b010:         lat_of = CNT_W'(LAT_MUL);
            3'b011:         lat_of = CNT_W'(LAT_DIV);
            3'b100:         lat_of = CNT_W'(LAT_SQRT);
            3'b101, 3'b110: lat_of = CNT_W'(LAT_CVT);
            default:        lat_of = '0;
        endcase
    endfunction

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    fop_t             r_held, r_pend, w_in, w_load_op;
    logic             r_pend_vld, r_illegal;
    logic             w_accept, w_load, w_pend_set, w_pend_clr, w_illegal_nxt;

    assign w_in        = {op, use_imm, dst_rd, rs, rt, rd, imm};
    assign issue_ready = !r_pend_vld;
    assign w_accept    = issue_valid & issue_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_load        = 1'b0;
        w_load_op     = w_in;
        w_pend_set    = 1'b0;
        w_pend_clr    = 1'b0;
        w_illegal_nxt = 1'b0;
        if (abort) begin
            // Flush wins over any same-cycle accept; held fields are left alone.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_pend_clr  = 1'b1;
        end else begin
            case (r_state)
                S_EXEC: begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_WB;
                    end
                    w_pend_set = w_accept;
                end
                S_IDLE, S_WB: begin
                    if (r_state == S_WB && r_pend_vld) begin
                        w_pend_clr = 1'b1;
                        if (r_pend.op == OP_ILL) begin
                            w_illegal_nxt = 1'b1;
                            w_state_nxt   = S_IDLE;
                        end else begin
                            w_load      = 1'b1;
                            w_load_op   = r_pend;
                            w_cnt_nxt   = lat_of(r_pend.op);
                            w_state_nxt = S_EXEC;
                        end
                    end else if (w_accept && op != OP_ILL) begin
                        // From WB this is the bypass path: no idle bubble.
                        w_load      = 1'b1;
                        w_cnt_nxt   = lat_of(op);
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_illegal_nxt = w_accept;
                        w_state_nxt   = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_held     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_illegal <= w_illegal_nxt;
            if (w_load) begin
                r_held <= w_load_op;
            end
            if (w_pend_set) begin
                r_pend <= w_in;
            end
            if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
            end else if (w_pend_set) begin
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign fp_alu_ctrl = r_held.op;
    assign fp_alu_src  = r_held.use_imm;
    assign fp_reg_dst  = r_held.dst_rd;
    assign fp_rs       = r_held.rs;
    assign fp_rt       = r_held.rt;
    assign fp_rd       = r_held.rd;
    assign fp_imm      = r_held.imm;
    // The strobe must never escape in a flush cycle, so it is gated combinationally.
    assign reg_write   = (r_state == S_WB) && !abort;
    assign done        = reg_write;
    assign illegal_op  = r_illegal;
    assign busy        = (r_state != S_IDLE) || r_pend_vld;

endmodule

// File: tb/tb_fp_issue_seq.sv
// Scoreboard bench for fp_issue_seq: expected write-backs and illegal pulses
// are queued at issue time and matched by a negedge monitor.
module tb_fp_issue_seq;

    logic        cpu_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid = 1'b0;
    logic        abort = 1'b0;
    logic        use_imm = 1'b0;
    logic        dst_rd = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [4:0]  rs = 5'd0;
    logic [4:0]  rt = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic [15:0] imm = 16'h0;
    logic        issue_ready, fp_alu_src, fp_reg_dst, reg_write, done, illegal_op, busy;
    logic [2:0]  fp_alu_ctrl;
    logic [4:0]  fp_rs, fp_rt, fp_rd;
    logic [15:0] fp_imm;

    fp_issue_seq dut (
        .cpu_clk(cpu_clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .op(op), .use_imm(use_imm), .dst_rd(dst_rd), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .abort(abort), .fp_alu_ctrl(fp_alu_ctrl), .fp_alu_src(fp_alu_src), .fp_reg_dst(fp_reg_dst),
        .fp_rs(fp_rs), .fp_rt(fp_rt), .fp_rd(fp_rd), .fp_imm(fp_imm), .reg_write(reg_write),
        .done(done), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    int cyc = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  op;
        logic        use_imm;
        logic        dst_rd;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          cyc;
    } exp_t;

    exp_t wq[$];
    int   iq[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic offer(input logic [2:0] o, input logic ui, input logic dr,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic [15:0] im, output int c0);
        op = o; use_imm = ui; dst_rd = dr; rs = s; rt = t; rd = d; imm = im;
        issue_valid = 1'b1;
        c0 = -1;
        for (int k = 0; k < 64 && !issue_ready; k++) @(negedge cpu_clk);
        if (!issue_ready) begin
            n_total++;
            $display("FAIL offer_timeout issue_ready=%b required=1", issue_ready);
        end else begin
            @(posedge cpu_clk);
            #1;
            c0 = cyc;
        end
    endtask

    task automatic drop();
        issue_valid = 1'b0;
    endtask

    task automatic push_w(input int c);
        exp_t e;
        e.op = op; e.use_imm = use_imm; e.dst_rd = dst_rd;
        e.rs = rs; e.rt = rt; e.rd = rd; e.imm = imm; e.cyc = c;
        wq.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        for (int k = 0; k < 300 && cyc < target; k++) @(negedge cpu_clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge cpu_clk);
        n_total++;
        if ({issue_ready, busy, reg_write, done, illegal_op} !== 5'b10000) begin
            $display("FAIL reset_ctrl got=%b required=10000", {issue_ready, busy, reg_write, done, illegal_op});
        end else n_pass++;
        n_total++;
        if ({fp_alu_ctrl, fp_alu_src, fp_reg_dst, fp_rs, fp_rt, fp_rd, fp_imm} !== 36'h0) begin
            $display("FAIL reset_fields got=%h required=0",
                     {fp_alu_ctrl, fp_alu_src, fp_reg_dst, fp_rs, fp_rt, fp_rd, fp_imm});
        end else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge cpu_clk);
        n_total++;
        if ({issue_ready, busy} !== 2'b10) begin
            $display("FAIL post_reset_idle ready_busy=%b required=10", {issue_ready, busy});
        end else n_pass++;
    endtask

    task automatic test_single_add();
        int c0;
        offer(3'b000, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 16'h0000, c0);
        push_w(c0 + 1);
        drop();
        n_total++;
        if ({fp_alu_ctrl, fp_rs, fp_rt, fp_rd, fp_reg_dst, busy, reg_write} !==
            {3'b000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL add_exec_fields ctrl=%b rd=%0d busy=%b wr=%b required ctrl=000 rd=3 busy=1 wr=0",
                     fp_alu_ctrl, fp_rd, busy, reg_write);
        end else n_pass++;
        wait_cyc(c0 + 3);
        n_total++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            $display("FAIL add_drain busy=%b pending_exp=%0d required busy=0 pending_exp=0", busy, wq.size());
        end else n_pass++;
    endtask

    task automatic test_pending();
        int c0, c1;
        offer(3'b100, 1'b1, 1'b0, 5'd4, 5'd5, 5'd6, 16'h00aa, c0);
        push_w(c0 + 12);
        drop();
        wait_cyc(c0 + 2);
        offer(3'b010, 1'b0, 1'b1, 5'd7, 5'd8, 5'd9, 16'h0101, c1);
        push_w(c0 + 16);
        drop();
        n_total++;
        if ({issue_ready, fp_alu_ctrl, fp_rd} !== {1'b0, 3'b100, 5'd6}) begin
            $display("FAIL pend_fill ready=%b ctrl=%b rd=%0d required ready=0 ctrl=100 rd=6",
                     issue_ready, fp_alu_ctrl, fp_rd);
        end else n_pass++;
        wait_cyc(c0 + 12);
        n_total++;
        if (issue_ready !== 1'b0) begin
            $display("FAIL pend_ready_in_wb got=%b required=0", issue_ready);
        end else n_pass++;
        wait_cyc(c0 + 13);
        n_total++;
        if ({issue_ready, fp_alu_ctrl, fp_rd} !== {1'b1, 3'b010, 5'd9}) begin
            $display("FAIL pend_promote ready=%b ctrl=%b rd=%0d required ready=1 ctrl=010 rd=9",
                     issue_ready, fp_alu_ctrl, fp_rd);
        end else n_pass++;
        wait_cyc(c0 + 18);
        n_total++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            $display("FAIL pend_drain busy=%b pending_exp=%0d required busy=0 pending_exp=0", busy, wq.size());
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c0, c1, c2;
        logic all_busy;
        offer(3'b000, 1'b0, 1'b1, 5'd1, 5'd1, 5'd10, 16'h0010, c0);
        push_w(c0 + 1);
        offer(3'b001, 1'b1, 1'b0, 5'd2, 5'd2, 5'd11, 16'h0011, c1);
        push_w(c0 + 3);
        offer(3'b000, 1'b0, 1'b1, 5'd3, 5'd3, 5'd12, 16'h0012, c2);
        push_w(c0 + 5);
        drop();
        all_busy = 1'b1;
        for (int k = 0; k < 20 && cyc < c0 + 5; k++) begin
            @(negedge cpu_clk);
            if (busy !== 1'b1) all_busy = 1'b0;
        end
        n_total++;
        if (all_busy !== 1'b1) begin
            $display("FAIL b2b_no_idle busy_throughout=%b required=1", all_busy);
        end else n_pass++;
        wait_cyc(c0 + 7);
        n_total++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            $display("FAIL b2b_drain busy=%b pending_exp=%0d required busy=0 pending_exp=0", busy, wq.size());
        end else n_pass++;
    endtask

    task automatic test_illegal();
        int c0, c1;
        offer(3'b111, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0000, c0);
        iq.push_back(c0);
        drop();
        n_total++;
        if ({busy, issue_ready} !== 2'b01) begin
            $display("FAIL ill_idle_stay busy_ready=%b required=01", {busy, issue_ready});
        end else n_pass++;
        wait_cyc(c0 + 3);
        offer(3'b000, 1'b0, 1'b1, 5'd2, 5'd3, 5'd13, 16'h0000, c0);
        push_w(c0 + 1);
        offer(3'b111, 1'b1, 1'b1, 5'd30, 5'd30, 5'd30, 16'hffff, c1);
        iq.push_back(c0 + 2);
        drop();
        wait_cyc(c0 + 2);
        n_total++;
        if ({busy, issue_ready, fp_rd} !== {1'b0, 1'b1, 5'd13}) begin
            $display("FAIL ill_pend_discard busy=%b ready=%b rd=%0d required busy=0 ready=1 rd=13",
                     busy, issue_ready, fp_rd);
        end else n_pass++;
        wait_cyc(c0 + 5);
        n_total++;
        if (wq.size() != 0 || iq.size() != 0) begin
            $display("FAIL ill_drain wq=%0d iq=%0d required 0 0", wq.size(), iq.size());
        end else n_pass++;
    endtask

    task automatic test_abort();
        int c0, c1;
        offer(3'b011, 1'b0, 1'b1, 5'd14, 5'd15, 5'd16, 16'h0000, c0);
        drop();
        offer(3'b010, 1'b0, 1'b1, 5'd17, 5'd17, 5'd17, 16'h0000, c1);
        drop();
        wait_cyc(c0 + 3);
        abort = 1'b1;
        @(posedge cpu_clk);
        #1;
        abort = 1'b0;
        n_total++;
        if ({busy, issue_ready, reg_write, fp_alu_ctrl, fp_rd} !== {1'b0, 1'b1, 1'b0, 3'b011, 5'd16}) begin
            $display("FAIL abort_exec busy=%b ready=%b wr=%b ctrl=%b rd=%0d required busy=0 ready=1 wr=0 ctrl=011 rd=16",
                     busy, issue_ready, reg_write, fp_alu_ctrl, fp_rd);
        end else n_pass++;
        repeat (15) @(negedge cpu_clk);
        offer(3'b000, 1'b0, 1'b1, 5'd18, 5'd18, 5'd18, 16'h0000, c0);
        drop();
        @(posedge cpu_clk);
        #1;
        n_total++;
        if (reg_write !== 1'b1) begin
            $display("FAIL abort_wb_pre wr=%b required=1", reg_write);
        end else n_pass++;
        abort = 1'b1;
        #1;
        n_total++;
        if ({reg_write, done} !== 2'b00) begin
            $display("FAIL abort_wb_gate wr_done=%b required=00", {reg_write, done});
        end else n_pass++;
        @(posedge cpu_clk);
        #1;
        abort = 1'b0;
        op = 3'b000; rd = 5'd19; issue_valid = 1'b1; abort = 1'b1;
        @(posedge cpu_clk);
        #1;
        issue_valid = 1'b0;
        abort = 1'b0;
        n_total++;
        if ({busy, fp_rd} !== {1'b0, 5'd18}) begin
            $display("FAIL abort_vs_accept busy=%b rd=%0d required busy=0 rd=18", busy, fp_rd);
        end else n_pass++;
        repeat (4) @(negedge cpu_clk);
        n_total++;
        if (wq.size() != 0 || iq.size() != 0 || busy !== 1'b0) begin
            $display("FAIL abort_drain wq=%0d iq=%0d busy=%b required 0 0 0", wq.size(), iq.size(), busy);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c0, c1;
        offer(3'b010, 1'b0, 1'b1, 5'd20, 5'd20, 5'd20, 16'h0020, c0);
        drop();
        for (int k = 0; k < 20 && cyc < c0 + 3; k++) begin
            @(posedge cpu_clk);
            #1;
        end
        n_total++;
        if (reg_write !== 1'b1) begin
            $display("FAIL rstmid_wb_pre wr=%b required=1", reg_write);
        end else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({reg_write, done, busy, illegal_op, issue_ready, fp_alu_ctrl, fp_rd, fp_imm} !==
            {5'b00001, 3'b000, 5'd0, 16'h0}) begin
            $display("FAIL rstmid_outputs wr=%b done=%b busy=%b ready=%b ctrl=%b rd=%0d required 0 0 0 1 000 0",
                     reg_write, done, busy, issue_ready, fp_alu_ctrl, fp_rd);
        end else n_pass++;
        @(negedge cpu_clk);
        rst_n = 1'b1;
        @(negedge cpu_clk);
        offer(3'b001, 1'b1, 1'b0, 5'd21, 5'd22, 5'd23, 16'h5a5a, c1);
        push_w(c1 + 1);
        drop();
        wait_cyc(c1 + 3);
        n_total++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            $display("FAIL rstmid_restart busy=%b pending_exp=%0d required busy=0 pending_exp=0", busy, wq.size());
        end else n_pass++;
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                int   ic;
                @(negedge cpu_clk);
                if (rst_n) begin
                    if (reg_write || done) begin
                        n_total++;
                        if (wq.size() == 0) begin
                            $display("FAIL wb_unexpected cyc=%0d wr=%b done=%b rd=%0d required no write",
                                     cyc, reg_write, done, fp_rd);
                        end else begin
                            e = wq.pop_front();
                            if ({reg_write, done, fp_alu_ctrl, fp_alu_src, fp_reg_dst, fp_rs, fp_rt, fp_rd, fp_imm} !==
                                {2'b11, e.op, e.use_imm, e.dst_rd, e.rs, e.rt, e.rd, e.imm} || cyc != e.cyc) begin
                                $display("FAIL wb_match cyc=%0d wr=%b done=%b ctrl=%b src=%b dst=%b rs=%0d rt=%0d rd=%0d imm=%h required cyc=%0d ctrl=%b src=%b dst=%b rs=%0d rt=%0d rd=%0d imm=%h",
                                         cyc, reg_write, done, fp_alu_ctrl, fp_alu_src, fp_reg_dst, fp_rs, fp_rt, fp_rd, fp_imm,
                                         e.cyc, e.op, e.use_imm, e.dst_rd, e.rs, e.rt, e.rd, e.imm);
                            end else n_pass++;
                        end
                    end
                    if (illegal_op) begin
                        n_total++;
                        if (iq.size() == 0) begin
                            $display("FAIL ill_unexpected cyc=%0d required no pulse", cyc);
                        end else begin
                            ic = iq.pop_front();
                            if (cyc != ic) begin
                                $display("FAIL ill_cycle got=%0d required=%0d", cyc, ic);
                            end else n_pass++;
                        end
                    end
                end
            end
        join_none

        test_reset();
        test_single_add();
        test_pending();
        test_back_to_back();
        test_illegal();
        test_abort();
        test_reset_mid();
        repeat (2) @(negedge cpu_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
